eth_pcs_block_lock: RTL and testbench

//  RX 64b/66b block-lock stage (IEEE 802.3 cl.49 lock FSM). Sits between RX gearbox and descrambler.

---
 rtl/eth_pcs_block_lock.sv | 148 ++++++++++++++
 tb/tb_eth_pcs_block_lock.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_block_lock.sv
// 64b/66b RX block lock: pulses o_slip to the gearbox until SH_CNT_MAX good sync headers arrive in a row.
// Payload/header outputs are registered with one enabled-cycle latency; no backpressure, i_clk_en gates all state.
module eth_pcs_block_lock #(
  parameter int W_DATA       = 32,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clk_en,
  input  logic [1:0]        i_hdr,
  input  logic              i_hdr_valid,
  input  logic [W_DATA-1:0] i_data,
  output logic [W_DATA-1:0] o_pld_data,
  output logic [1:0]        o_hdr,
  output logic              o_hdr_valid,
  output logic              o_block_lock,
  output logic              o_slip,
  output logic              o_hdr_err
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {
    ST_RESET_CNT,
    ST_TEST_SH,
    ST_SLIP,
    ST_SLIP_WAIT
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   sh_cnt, sh_cnt_nxt, sh_cnt_inc;
  logic [INV_W-1:0]   inv_cnt, inv_cnt_nxt, inv_cnt_inc;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic               lock_nxt;
  logic               slip_nxt;
  logic               hdr_err_nxt;
  logic               hdr_ok;

  // Exactly one of the two header bits set marks a legal sync header.
  assign hdr_ok      = i_hdr[1] ^ i_hdr[0];
  assign sh_cnt_inc  = sh_cnt + CNT_W'(1);
  assign inv_cnt_inc = inv_cnt + INV_W'(1);

  always_comb begin
    state_nxt    = state;
    sh_cnt_nxt   = sh_cnt;
    inv_cnt_nxt  = inv_cnt;
    wait_cnt_nxt = wait_cnt;
    lock_nxt     = o_block_lock;
    slip_nxt     = 1'b0;
    hdr_err_nxt  = o_hdr_err;

    if (i_clk_en) begin
      hdr_err_nxt = o_block_lock & i_hdr_valid & ~hdr_ok;

      case (state)
        ST_RESET_CNT: begin
          sh_cnt_nxt  = '0;
          inv_cnt_nxt = '0;
          state_nxt   = ST_TEST_SH;
        end

        ST_TEST_SH: begin
          if (i_hdr_valid) begin
            sh_cnt_nxt = sh_cnt_inc;
            if (!hdr_ok) inv_cnt_nxt = inv_cnt_inc;

            if (!o_block_lock) begin
              if (!hdr_ok) begin
                state_nxt = ST_SLIP;
              end else if (sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
                lock_nxt  = 1'b1;
                state_nxt = ST_RESET_CNT;
              end
            end else begin
              // Lock loss is checked first so it wins over a coincident window end.
              if (!hdr_ok && (inv_cnt_inc == INV_W'(SH_INVLD_MAX))) begin
                lock_nxt  = 1'b0;
                state_nxt = ST_SLIP;
              end else if (sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
                state_nxt = ST_RESET_CNT;
              end
            end
          end
        end

        ST_SLIP: begin
          slip_nxt     = 1'b1;
          sh_cnt_nxt   = '0;
          inv_cnt_nxt  = '0;
          wait_cnt_nxt = WAIT_W'(SLIP_WAIT);
          state_nxt    = ST_SLIP_WAIT;
        end

        ST_SLIP_WAIT: begin
          // Headers here come from a realigning gearbox and are not judged.
          if (wait_cnt == '0) begin
            state_nxt = ST_RESET_CNT;
          end else if (i_hdr_valid) begin
            wait_cnt_nxt = wait_cnt - WAIT_W'(1);
            if (wait_cnt == WAIT_W'(1)) state_nxt = ST_RESET_CNT;
          end
        end

        default: begin
          state_nxt = ST_RESET_CNT;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= ST_RESET_CNT;
      sh_cnt       <= '0;
      inv_cnt      <= '0;
      wait_cnt     <= '0;
      o_block_lock <= 1'b0;
      o_slip       <= 1'b0;
      o_hdr_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      sh_cnt       <= sh_cnt_nxt;
      inv_cnt      <= inv_cnt_nxt;
      wait_cnt     <= wait_cnt_nxt;
      o_block_lock <= lock_nxt;
      o_slip       <= slip_nxt;
      o_hdr_err    <= hdr_err_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_pld_data  <= '0;
      o_hdr       <= '0;
      o_hdr_valid <= 1'b0;
    end else if (i_clk_en) begin
      o_pld_data  <= i_data;
      o_hdr       <= i_hdr;
      o_hdr_valid <= i_hdr_valid;
    end
  end

endmodule

// File: tb/tb_eth_pcs_block_lock.sv
// Directed bench for eth_pcs_block_lock: lock acquisition, slip, lock loss, clock enable and reset.
module tb_eth_pcs_block_lock;

  localparam int W_DATA = 32;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_clk_en = 1'b0;
  logic [1:0]        i_hdr = 2'b00;
  logic              i_hdr_valid = 1'b0;
  logic [W_DATA-1:0] i_data = '0;
  logic [W_DATA-1:0] o_pld_data;
  logic [1:0]        o_hdr;
  logic              o_hdr_valid;
  logic              o_block_lock;
  logic              o_slip;
  logic              o_hdr_err;

  eth_pcs_block_lock #(
    .W_DATA(W_DATA), .SH_CNT_MAX(64), .SH_INVLD_MAX(16), .SLIP_WAIT(4)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en),
    .i_hdr(i_hdr), .i_hdr_valid(i_hdr_valid), .i_data(i_data),
    .o_pld_data(o_pld_data), .o_hdr(o_hdr), .o_hdr_valid(o_hdr_valid),
    .o_block_lock(o_block_lock), .o_slip(o_slip), .o_hdr_err(o_hdr_err)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  int slip_cnt = 0;
  int err_cnt  = 0;
  int dcnt     = 0;

  logic [W_DATA-1:0] exp_pld = '0;
  logic [1:0]        exp_hdr = '0;
  logic              exp_hv  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One gearbox word; outputs sampled 1 time unit after the edge.
  task automatic drive_word(input logic en, input logic hv, input logic [1:0] hdr);
    logic [15:0] d;
    d           = dcnt[15:0];
    i_clk_en    = en;
    i_hdr_valid = hv;
    i_hdr       = hdr;
    i_data      = {d, ~d};
    dcnt++;
    @(posedge i_clk);
    #1;
    if (en) begin
      exp_pld = i_data;
      exp_hdr = hdr;
      exp_hv  = hv;
    end
    chk("pld_data", 64'(o_pld_data), 64'(exp_pld));
    chk("hdr", 64'(o_hdr), 64'(exp_hdr));
    chk("hdr_valid", 64'(o_hdr_valid), 64'(exp_hv));
    if (o_slip) slip_cnt++;
    if (en && o_hdr_err) err_cnt++;
  endtask

  task automatic send_block(input logic [1:0] hdr);
    drive_word(1'b1, 1'b1, hdr);
    drive_word(1'b1, 1'b0, 2'b00);
  endtask

  // Asserts reset mid-cycle, checks the immediate clear, releases after the next edge.
  task automatic do_reset();
    i_reset = 1'b1;
    #1;
    i_reset = 1'b0;
    #2;
    chk("rst_pld", 64'(o_pld_data), 64'd0);
    chk("rst_hdr", 64'(o_hdr), 64'd0);
    chk("rst_hv", 64'(o_hdr_valid), 64'd0);
    chk("rst_lock", 64'(o_block_lock), 64'd0);
    chk("rst_slip", 64'(o_slip), 64'd0);
    chk("rst_err", 64'(o_hdr_err), 64'd0);
    exp_pld  = '0;
    exp_hdr  = '0;
    exp_hv   = 1'b0;
    i_clk_en = 1'b0;
    i_hdr_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset  = 1'b1;
    slip_cnt = 0;
    err_cnt  = 0;
  endtask

  initial begin
    // 1: first header lands in RESET_CNT, so lock arrives on block 65.
    do_reset();
    for (int b = 1; b <= 64; b++) send_block(2'b01);
    chk("t1_lock_before", 64'(o_block_lock), 64'd0);
    drive_word(1'b1, 1'b1, 2'b01);
    chk("t1_lock_after", 64'(o_block_lock), 64'd1);
    drive_word(1'b1, 1'b0, 2'b00);
    chk("t1_slips", 64'(slip_cnt), 64'd0);

    // 3: 15 invalid headers in a window keep lock.
    err_cnt = 0;
    for (int b = 0; b < 64; b++) send_block((b % 4 == 1 && b < 60) ? 2'b00 : 2'b10);
    chk("t3_lock", 64'(o_block_lock), 64'd1);
    chk("t3_err_pulses", 64'(err_cnt), 64'd15);
    chk("t3_slips", 64'(slip_cnt), 64'd0);

    // 4: 16th invalid header drops lock, slip next cycle, slip cleared even with clk_en low.
    err_cnt = 0;
    for (int b = 0; b < 15; b++) send_block(2'b00);
    chk("t4_lock_held", 64'(o_block_lock), 64'd1);
    drive_word(1'b1, 1'b1, 2'b00);
    chk("t4_lock_lost", 64'(o_block_lock), 64'd0);
    chk("t4_err_last", 64'(o_hdr_err), 64'd1);
    chk("t4_no_slip_yet", 64'(o_slip), 64'd0);
    drive_word(1'b1, 1'b0, 2'b00);
    chk("t4_slip", 64'(o_slip), 64'd1);
    drive_word(1'b0, 1'b0, 2'b00);
    chk("t4_slip_clear", 64'(o_slip), 64'd0);
    chk("t4_err_pulses", 64'(err_cnt), 64'd16);

    // 2: bad header at block 10, blocks 11-14 ignored, counting resumes at block 15.
    do_reset();
    for (int b = 1; b <= 9; b++) send_block(2'b01);
    drive_word(1'b1, 1'b1, 2'b11);
    chk("t2_no_slip_yet", 64'(o_slip), 64'd0);
    drive_word(1'b1, 1'b0, 2'b00);
    chk("t2_slip", 64'(o_slip), 64'd1);
    for (int b = 11; b <= 14; b++) send_block(2'b11);
    chk("t2_slip_once", 64'(slip_cnt), 64'd1);
    for (int b = 15; b <= 77; b++) send_block(2'b01);
    chk("t2_lock_before", 64'(o_block_lock), 64'd0);
    drive_word(1'b1, 1'b1, 2'b01);
    chk("t2_lock_after", 64'(o_block_lock), 64'd1);
    drive_word(1'b1, 1'b0, 2'b00);
    chk("t2_slips", 64'(slip_cnt), 64'd1);
    chk("t2_err_unlocked", 64'(err_cnt), 64'd0);

    // 5: clk_en alternates; disabled cycles carry garbage that must be ignored.
    do_reset();
    for (int b = 1; b <= 65; b++) begin
      if (b == 65) chk("t5_lock_before", 64'(o_block_lock), 64'd0);
      drive_word(1'b1, 1'b1, 2'b01);
      drive_word(1'b0, 1'b1, 2'b11);
      if (b == 65) chk("t5_lock_after", 64'(o_block_lock), 64'd1);
      drive_word(1'b1, 1'b0, 2'b00);
      drive_word(1'b0, 1'b1, 2'b00);
    end
    chk("t5_slips", 64'(slip_cnt), 64'd0);

    // 6: reset while locked mid-window, then a full relock.
    do_reset();
    for (int b = 1; b <= 65; b++) send_block(2'b10);
    chk("t6_locked", 64'(o_block_lock), 64'd1);
    for (int b = 0; b < 20; b++) send_block(2'b01);
    do_reset();
    for (int b = 1; b <= 64; b++) send_block(2'b01);
    chk("t6_relock_before", 64'(o_block_lock), 64'd0);
    drive_word(1'b1, 1'b1, 2'b01);
    chk("t6_relock_after", 64'(o_block_lock), 64'd1);
    drive_word(1'b1, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
